// File: rtl/multiphase_sinusoid_scheduler_pkg.sv
// Shared types and default sizing for the multiphase sinusoid scheduler.
package multiphase_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } sched_state_t;

  localparam int unsigned DEF_N_PHASES        = 6;
  localparam int unsigned DEF_ANGLE_WIDTH     = 16;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 255;

  localparam int unsigned IDX_W = $clog2(DEF_N_PHASES);
  localparam int unsigned OUT_W = $clog2(DEF_MAX_OUTSTANDING + 1);

  // Phase index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multiphase_sinusoid_scheduler_if.sv
// Minimal stream channel: valid/ready handshake with data and destination.
interface axi_stream #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEST_W = 3
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [DEST_W-1:0] dest;

  modport master (output valid, output data, output dest, input ready);
  modport slave  (input valid, input data, input dest, output ready);

endinterface

// File: rtl/multiphase_sinusoid_scheduler_progress_watchdog.sv
// Progress watchdog: counts enabled cycles without a handshake and flags
// the cycle in which the count reaches LIMIT.
module progress_watchdog
  import multiphase_sched_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Terminal count: this is the LIMIT-th consecutive idle busy cycle.
  assign expired = enable & ~clear & (count == CW'(LIMIT - 1));

  // Idle-cycle counter, restarted by any handshake or when not busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!enable || clear) begin
      count <= '0;
    end else if (count != CW'(LIMIT)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/multiphase_sinusoid_scheduler.sv
// Fans one base angle out into N_PHASES shifted requests to a shared
// sin/cos engine, caps outstanding requests, tracks in-order responses and
// raises sticky overrun / ordering / timeout flags.
module multiphase_sinusoid_scheduler
  import multiphase_sched_pkg::*;
#(
  parameter int unsigned N_PHASES        = DEF_N_PHASES,
  parameter int unsigned ANGLE_WIDTH     = DEF_ANGLE_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                                  clock,
  input  logic                                  reset,
  axi_stream.slave                              phase,
  input  logic [N_PHASES-1:0][ANGLE_WIDTH-1:0]  phase_shifts,
  axi_stream.master                             engine_req,
  axi_stream.slave                              engine_resp,
  input  logic                                  clear_errors,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overrun,
  output logic                                  order_error,
  output logic                                  timeout
);

  localparam int unsigned IW = idx_width(N_PHASES);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PHASES - 1);
  localparam logic [OW-1:0] CAP      = OW'(MAX_OUTSTANDING);

  sched_state_t                          state;
  logic [ANGLE_WIDTH-1:0]                angle_q;
  logic [N_PHASES-1:0][ANGLE_WIDTH-1:0]  shifts_q;
  logic [IW-1:0]                         issue_idx;
  logic [IW-1:0]                         exp_idx;
  logic [IW-1:0]                         next_idx;
  logic [OW-1:0]                         outstanding;
  logic [OW-1:0]                         out_next;
  logic                                  req_valid;
  logic [ANGLE_WIDTH-1:0]                req_data;
  logic [IW-1:0]                         req_dest;
  logic                                  req_hs;
  logic                                  resp_hs;
  logic                                  resp_live;
  logic                                  resp_unexpected;
  logic                                  resp_misorder;
  logic                                  wd_expired;
  logic                                  unused_inputs;

  assign phase.ready       = 1'b1;
  assign engine_resp.ready = 1'b1;
  assign engine_req.valid  = req_valid;
  assign engine_req.data   = req_data;
  assign engine_req.dest   = req_dest;
  assign unused_inputs     = ^{phase.dest, engine_resp.data};

  // Handshake decode and next outstanding count.
  always_comb begin
    req_hs          = req_valid & engine_req.ready;
    resp_hs         = engine_resp.valid;
    resp_live       = resp_hs & (outstanding != '0);
    resp_unexpected = resp_hs & (outstanding == '0);
    resp_misorder   = resp_live & (engine_resp.dest != exp_idx);
    next_idx        = issue_idx + IW'(1);
    out_next        = outstanding;
    if (req_hs && !resp_live) begin
      out_next = outstanding + OW'(1);
    end else if (!req_hs && resp_live) begin
      out_next = outstanding - OW'(1);
    end
  end

  progress_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .enable  (busy),
    .clear   (req_hs | resp_hs),
    .expired (wd_expired)
  );

  // Scheduler FSM with registered request channel, status and sticky flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      angle_q     <= '0;
      shifts_q    <= '0;
      issue_idx   <= '0;
      exp_idx     <= '0;
      outstanding <= '0;
      req_valid   <= 1'b0;
      req_data    <= '0;
      req_dest    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      order_error <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      done        <= 1'b0;
      overrun     <= (overrun & ~clear_errors) | (phase.valid & (state != IDLE));
      order_error <= (order_error & ~clear_errors) | resp_unexpected | resp_misorder;
      timeout     <= (timeout & ~clear_errors) | wd_expired;
      outstanding <= out_next;
      if (resp_live) begin
        exp_idx <= exp_idx + IW'(1);
      end

      if (wd_expired) begin
        state       <= IDLE;
        busy        <= 1'b0;
        req_valid   <= 1'b0;
        outstanding <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (phase.valid) begin
              angle_q   <= phase.data;
              shifts_q  <= phase_shifts;
              issue_idx <= '0;
              exp_idx   <= '0;
              req_data  <= phase.data + phase_shifts[0];
              req_dest  <= '0;
              req_valid <= (out_next < CAP);
              busy      <= 1'b1;
              state     <= ISSUE;
            end
          end
          ISSUE: begin
            if (req_hs && issue_idx == LAST_IDX) begin
              req_valid <= 1'b0;
              state     <= DRAIN;
            end else begin
              if (req_hs) begin
                issue_idx <= next_idx;
                req_data  <= angle_q + shifts_q[next_idx];
                req_dest  <= next_idx;
              end
              // Cap on the post-update count: a response only re-opens the
              // channel from the following cycle.
              req_valid <= (out_next < CAP);
            end
          end
          DRAIN: begin
            // done is raised while still in DRAIN, then the FSM returns to IDLE.
            if (done) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (out_next == '0) begin
              done <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multiphase_sinusoid_scheduler.sv
// Scoreboard bench for the multiphase sinusoid scheduler: stimulus pushes the
// expected request stream, an engine/monitor process answers and compares.
module tb_multiphase_sinusoid_scheduler;

  localparam int N    = 6;
  localparam int AW   = 16;
  localparam int MAXO = 4;
  localparam int TMO  = 255;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0][AW-1:0] shifts;
  logic clear_errors;
  logic busy, done, overrun, order_error, timeout;

  axi_stream #(.DATA_W(AW), .DEST_W(3)) phase_if ();
  axi_stream #(.DATA_W(AW), .DEST_W(3)) req_if ();
  axi_stream #(.DATA_W(AW), .DEST_W(3)) resp_if ();

  multiphase_sinusoid_scheduler #(
    .N_PHASES        (N),
    .ANGLE_WIDTH     (AW),
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .phase        (phase_if),
    .phase_shifts (shifts),
    .engine_req   (req_if),
    .engine_resp  (resp_if),
    .clear_errors (clear_errors),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .order_error  (order_error),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [AW-1:0] data; int dest; } req_t;
  typedef struct { int dest; int due; } eng_t;

  req_t exp_q[$];
  eng_t eng_q[$];
  int   exp_done      = 0;
  int   done_cnt      = 0;
  int   hs_count      = 0;
  int   hs_cyc        = 0;
  int   last_resp_cyc = 0;
  int   rel_cyc       = 0;
  int   model_out     = 0;
  bit   resp_enable   = 1'b1;
  bit   rand_ready    = 1'b0;
  bit   rand_lat      = 1'b0;
  int   lat           = 3;
  int   release_one   = 0;
  int   stall_at      = -1;
  int   stall_left    = 0;
  int   corrupt_at    = -1;
  bit   flush_req     = 1'b0;
  bit   prev_stall    = 1'b0;
  logic [AW-1:0] prev_data;
  logic [2:0]    prev_dest;

  task automatic flush_all();
    exp_q.delete();
    eng_q.delete();
    exp_done   = 0;
    model_out  = 0;
    prev_stall = 1'b0;
    stall_left = 0;
  endtask

  // Engine model and monitor: answers requests, checks the request stream,
  // handshake stability and done timing.
  always @(negedge clock) begin
    if (!reset || flush_req) begin
      flush_all();
      flush_req     = 1'b0;
      resp_if.valid = 1'b0;
      req_if.ready  = 1'b1;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(req_if.valid), 32'd1);
        check("hold_data", 32'(req_if.data), 32'(prev_data));
        check("hold_dest", 32'(req_if.dest), 32'(prev_dest));
      end

      if (done) begin
        if (exp_done == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          check("done_timing", 32'(cyc), 32'(last_resp_cyc + 1));
          exp_done--;
        end
        done_cnt++;
      end

      resp_if.valid = 1'b0;
      if (eng_q.size() > 0 && eng_q[0].due <= cyc && (resp_enable || release_one > 0)) begin
        eng_t e;
        e = eng_q.pop_front();
        resp_if.valid = 1'b1;
        resp_if.dest  = 3'(e.dest);
        if (corrupt_at == e.dest) begin
          resp_if.dest = 3'(e.dest + 1);
          corrupt_at   = -1;
        end
        model_out--;
        last_resp_cyc = cyc;
        if (release_one > 0) begin
          release_one--;
          rel_cyc = cyc;
        end
      end

      if (stall_left > 0) begin
        req_if.ready = 1'b0;
        stall_left--;
      end else if (stall_at >= 0 && req_if.valid === 1'b1 && int'(req_if.dest) == stall_at) begin
        req_if.ready = 1'b0;
        stall_left   = 4;
        stall_at     = -1;
      end else if (rand_ready) begin
        req_if.ready = ($urandom_range(0, 3) != 0);
      end else begin
        req_if.ready = 1'b1;
      end

      if (req_if.valid === 1'b1 && req_if.ready) begin
        eng_t e;
        int   li;
        if (exp_q.size() == 0) begin
          check("req_unexpected", 32'(req_if.valid), 32'd0);
        end else begin
          req_t r;
          r = exp_q.pop_front();
          check("req_data", 32'(req_if.data), 32'(r.data));
          check("req_dest", 32'(req_if.dest), 32'(r.dest));
        end
        li    = rand_lat ? int'($urandom_range(1, 4)) : lat;
        e.dest = int'(req_if.dest);
        e.due  = cyc + li;
        if (eng_q.size() > 0 && eng_q[$].due > e.due) e.due = eng_q[$].due;
        eng_q.push_back(e);
        model_out++;
        check("cap_respected", 32'(model_out <= MAXO), 32'd1);
        hs_count++;
        hs_cyc = cyc;
      end

      prev_stall = (req_if.valid === 1'b1) && !req_if.ready;
      prev_data  = req_if.data;
      prev_dest  = req_if.dest;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_reqs(input logic [AW-1:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      req_t r;
      r.data = AW'((int'(a) + int'(shifts[i])) % 65536);
      r.dest = i;
      exp_q.push_back(r);
    end
  endtask

  task automatic push_set(input logic [AW-1:0] a);
    push_reqs(a, N);
    exp_done++;
  endtask

  task automatic send(input logic [AW-1:0] a);
    phase_if.valid = 1'b1;
    phase_if.data  = a;
    tick();
    phase_if.valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound, input string name);
    for (int i = 0; i < bound && done_cnt < target; i++) tick();
    check(name, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_hs(input int target, input int bound, input string name);
    for (int i = 0; i < bound && hs_count < target; i++) tick();
    check(name, 32'(hs_count), 32'(target));
  endtask

  logic [31:0] outs;
  assign outs = {7'd0, req_if.valid, req_if.data, req_if.dest,
                 busy, done, overrun, order_error, timeout};

  initial begin
    logic [AW-1:0] a;
    int base;
    int dc;

    phase_if.valid = 1'b0;
    phase_if.data  = '0;
    phase_if.dest  = '0;
    req_if.ready   = 1'b1;
    resp_if.valid  = 1'b0;
    resp_if.data   = '0;
    resp_if.dest   = '0;
    clear_errors   = 1'b0;
    shifts[0] = 16'd0;     shifts[1] = 16'd10923; shifts[2] = 16'd21845;
    shifts[3] = 16'd32768; shifts[4] = 16'd43691; shifts[5] = 16'd54613;

    #1;
    check("reset_outputs", outs, 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    tick();
    check("idle_after_reset", outs, 32'd0);

    // Reference set with hand-computed request values.
    begin
      logic [AW-1:0] lit [6];
      lit = '{16'h1000, 16'h3AAB, 16'h6555, 16'h9000, 16'hBAAB, 16'hE555};
      for (int i = 0; i < N; i++) begin
        req_t r;
        r.data = lit[i];
        r.dest = i;
        exp_q.push_back(r);
      end
      exp_done++;
    end
    send(16'h1000);
    check("first_req_valid", 32'(req_if.valid), 32'd1);
    check("first_req_dest", 32'(req_if.dest), 32'd0);
    check("busy_set", 32'(busy), 32'd1);
    wait_done(1, 100, "t1_done");
    tick();
    check("busy_clear", 32'(busy), 32'd0);

    // Wrapping sum and a five-cycle ready stall at index 2.
    stall_at = 2;
    push_set(16'hF000);
    send(16'hF000);
    wait_done(2, 100, "t2_done");

    // Outstanding cap with a silent engine, then a single release.
    resp_enable = 1'b0;
    a = AW'($urandom);
    base = hs_count;
    push_set(a);
    send(a);
    wait_hs(base + 4, 50, "cap_four_issued");
    repeat (3) tick();
    check("cap_valid_low", 32'(req_if.valid), 32'd0);
    check("cap_no_fifth", 32'(hs_count), 32'(base + 4));
    release_one = 1;
    wait_hs(base + 5, 20, "cap_fifth_issued");
    check("cap_fifth_timing", 32'(hs_cyc), 32'(rel_cyc + 1));
    resp_enable = 1'b1;
    wait_done(3, 100, "t3_done");

    // Overrun while issuing, then clear.
    a = AW'($urandom);
    push_set(a);
    send(a);
    tick();
    phase_if.valid = 1'b1;
    phase_if.data  = AW'($urandom);
    tick();
    phase_if.valid = 1'b0;
    tick();
    check("overrun_set", 32'(overrun), 32'd1);
    wait_done(4, 100, "t4_done");
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Misordered response still completes the set.
    corrupt_at = 2;
    a = AW'($urandom);
    push_set(a);
    send(a);
    wait_done(5, 100, "t5_done");
    check("order_error_set", 32'(order_error), 32'd1);

    // Silent engine trips the watchdog.
    resp_enable = 1'b0;
    a = AW'($urandom);
    push_reqs(a, MAXO);
    send(a);
    for (int i = 0; i < 400 && timeout !== 1'b1; i++) tick();
    check("timeout_set", 32'(timeout), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_req_valid", 32'(req_if.valid), 32'd0);
    dc = done_cnt;
    flush_req = 1'b1;
    repeat (5) tick();
    resp_enable = 1'b1;
    check("timeout_no_done", 32'(done_cnt), 32'(dc));

    // Asynchronous reset in the middle of issuing.
    a = AW'($urandom);
    push_set(a);
    send(a);
    tick();
    @(posedge clock);
    #3 reset = 1'b0;
    #1 check("async_reset_outputs", outs, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    dc = done_cnt;
    a = AW'($urandom);
    push_set(a);
    send(a);
    wait_done(dc + 1, 100, "post_reset_done");
    check("post_reset_flags", {29'd0, overrun, order_error, timeout}, 32'd0);

    // Randomized sets with random ready and response latency; shifts change
    // right after accept to exercise the snapshot.
    rand_ready = 1'b1;
    rand_lat   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N; i++) shifts[i] = AW'($urandom);
      a = AW'($urandom);
      dc = done_cnt;
      push_set(a);
      send(a);
      for (int i = 0; i < N; i++) shifts[i] = AW'($urandom);
      wait_done(dc + 1, 300, "rand_done");
    end
    rand_ready = 1'b0;
    rand_lat   = 1'b0;
    repeat (5) tick();

    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("engine_queue_empty", 32'(eng_q.size()), 32'd0);
    check("done_all_seen", 32'(exp_done), 32'd0);
    check("final_flags", {29'd0, overrun, order_error, timeout}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
